aux_reply_ctrl: RTL and testbench
=================================

# aux_reply_ctrl

Sequences one AUX request/reply exchange on the reply side of the AUX channel. It consumes the decoded command byte and data bytes from the reply decoder and waits for the reply with a timeout. It forwards data bytes for ACK replies only and retries on DEFER or timeout up to a retry limit. It reports one completion pulse with a status code and received-byte count to the transaction layer.

## Interface
- TIMEOUT_CYCLES, 4000, clock cycles allowed from req_sent to first reply_ack_vld
- MAX_RETRY, 7, retries permitted after the first attempt
- RETRY_GAP, 16, idle cycles between DEFER/timeout decision and retry_req
- clk  input  1  single clock
- rst  input  1  asynchronous, active-low reset
- req_sent  input  1  1-cycle pulse: request fully transmitted, reply window opens
- req_len  input  5  expected data bytes (0..16); sampled on req_sent from IDLE only
- reply_ack  input  2  decoded reply command: 00 ACK, 01 NACK, 10 DEFER, 11 reserved
- reply_ack_vld  input  1  high for the first byte of a reply
- reply_data  input  8  data byte
- reply_data_vld  input  1  high for each data byte after the command byte
- reply_dec_i2c_native  input  1  transaction type reported by the decoder
- rd_data  output  8  forwarded data byte
- rd_data_vld  output  1  rd_data valid, one cycle per byte
- retry_req  output  1  1-cycle pulse: retransmit the same request
- busy  output  1  high outside IDLE
- done  output  1  1-cycle completion pulse
- status  output  2  00 ACK, 01 NACK/reserved, 10 timeout exhausted, 11 DEFER exhausted; valid with done, held until next done
- rx_len  output  5  bytes forwarded; valid with done, held
- rx_i2c_native  output  1  latched reply_dec_i2c_native of final reply; held

## Operation
- States:
  - IDLE
  - WAIT_REPLY: timer runs
  - RECV
  - GAP: RETRY_GAP counter
  - WAIT_TX: awaiting retransmission
- IDLE:
  - On req_sent, latch req_len, clear retry_cnt, byte_cnt and timer, then go to WAIT_REPLY.
  - reply_* inputs are ignored.
- WAIT_REPLY:
  - timer increments each cycle.
  - On reply_ack_vld, latch reply_ack and reply_dec_i2c_native, then go to RECV. reply_ack_vld takes priority over a same-cycle timer expiry.
  - When timer reaches TIMEOUT_CYCLES-1 without reply_ack_vld, this is a timeout event.
- RECV:
  - Each reply_data_vld cycle with latched ack==00 and byte_cnt<len_q forwards the byte and increments byte_cnt.
  - Bytes beyond len_q are dropped silently.
  - Bytes received with a non-ACK command are dropped.
  - The first cycle with reply_ack_vld=0 and reply_data_vld=0 is end-of-reply. On it, evaluate the latched ack:
    - 00 → done, status 00.
    - 01 or 11 → done, status 01.
    - 10 → DEFER event.
- DEFER or timeout event:
  - If retry_cnt==MAX_RETRY, finish: done with status 11 (DEFER) or 10 (timeout).
  - Otherwise increment retry_cnt, clear byte_cnt, and go to GAP.
- GAP: after RETRY_GAP cycles, pulse retry_req and go to WAIT_TX.
- WAIT_TX: on req_sent, clear timer and go to WAIT_REPLY. len_q is retained.
- Completion: pulse done, load status, rx_len=byte_cnt and rx_i2c_native, then go to IDLE.
- req_sent outside IDLE/WAIT_TX is ignored.
- retry_cnt is 3 bits wide; MAX_RETRY ≤ 7. The timer is wide enough for TIMEOUT_CYCLES and saturates.

## Timing
- Reset values: rd_data 0, rd_data_vld 0, retry_req 0, busy 0, done 0, status 00, rx_len 0, rx_i2c_native 0. All internal counters reset to 0, and the state resets to IDLE.
- Reset mid-transaction aborts immediately. No done or retry_req is issued.
- rd_data/rd_data_vld are registered: they appear one cycle after the reply_data_vld cycle.
- done/status/rx_len are asserted the cycle after the end-of-reply cycle, or the cycle after the timer expiry cycle. busy falls in the same cycle as done.
- busy rises the cycle after the accepted req_sent.
- retry_req pulses exactly RETRY_GAP+1 cycles after the decision cycle.
- After done, a req_sent in the following cycle is accepted normally.
- Timeout measurement: TIMEOUT_CYCLES cycles after the req_sent cycle, with no reply_ack_vld, produces a timeout event.

## Test plan
- ACK read: req_len=4, reply ACK followed by 0x11,0x22,0x33,0x44 → rd_data 0x11..0x44 on 4 consecutive cycles; done with status 00, rx_len 4.
- Over-length: req_len=2, reply ACK plus 4 bytes → only 0x11,0x22 forwarded; rx_len 2.
- NACK: reply command 01 with 1 data byte → no rd_data_vld; done with status 01, rx_len 0, no retry_req.
- DEFER then ACK: DEFER reply → retry_req 17 cycles after the decision; req_sent; ACK with 1 byte → done status 00, retry count invisible, exactly one retry_req.
- Timeout exhaustion: MAX_RETRY=2, no replies → 2 retry_req pulses; done status 10 after the third TIMEOUT_CYCLES window.
- Reset during RECV after 2 bytes: rst low for 1 cycle → all outputs 0, no done; the next transaction behaves from IDLE.

Source files
------------

// File: rtl/aux_reply_ctrl.sv
// rtl/aux_reply_ctrl.sv - AUX reply-side sequencer: reply wait, data forwarding, DEFER/timeout retry
module aux_reply_ctrl #(
  parameter int TIMEOUT_CYCLES = 4000,
  parameter int MAX_RETRY      = 7,
  parameter int RETRY_GAP      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_sent,
  input  logic [4:0] req_len,
  input  logic [1:0] reply_ack,
  input  logic       reply_ack_vld,
  input  logic [7:0] reply_data,
  input  logic       reply_data_vld,
  input  logic       reply_dec_i2c_native,
  output logic [7:0] rd_data,
  output logic       rd_data_vld,
  output logic       retry_req,
  output logic       busy,
  output logic       done,
  output logic [1:0] status,
  output logic [4:0] rx_len,
  output logic       rx_i2c_native
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = (RETRY_GAP > 1) ? $clog2(RETRY_GAP) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT_CYCLES);
  localparam logic [GW-1:0] G_LAST = GW'(RETRY_GAP - 1);
  localparam logic [2:0]    MAX_Q  = 3'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_REPLY,
    S_RECV,
    S_GAP,
    S_WAIT_TX
  } state_t;

  state_t state, state_nxt;

  logic [4:0]    len_q;
  logic [4:0]    byte_cnt;
  logic [2:0]    retry_cnt;
  logic [TW-1:0] timer;
  logic [GW-1:0] gap_cnt;
  logic [1:0]    ack_q;
  logic          i2c_q;

  logic       start;
  logic       rearm;
  logic       latch_reply;
  logic       fwd;
  logic       finish;
  logic       to_gap;
  logic       fire_retry;
  logic       retry_event;
  logic [1:0] fin_status;
  logic [1:0] event_status;

  assign busy = (state != S_IDLE);

  // State register; reset aborts any exchange without a completion pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state and per-cycle strobes; DEFER and timeout share one retry-or-give-up decision.
  always_comb begin
    state_nxt    = state;
    start        = 1'b0;
    rearm        = 1'b0;
    latch_reply  = 1'b0;
    fwd          = 1'b0;
    finish       = 1'b0;
    to_gap       = 1'b0;
    fire_retry   = 1'b0;
    retry_event  = 1'b0;
    fin_status   = 2'b00;
    event_status = 2'b00;
    case (state)
      S_IDLE: begin
        if (req_sent) begin
          start     = 1'b1;
          state_nxt = S_WAIT_REPLY;
        end
      end
      S_WAIT_REPLY: begin
        // A reply arriving on the expiry cycle still wins.
        if (reply_ack_vld) begin
          latch_reply = 1'b1;
          state_nxt   = S_RECV;
        end else if (timer == T_LAST) begin
          retry_event  = 1'b1;
          event_status = 2'b10;
        end
      end
      S_RECV: begin
        if (reply_data_vld) begin
          fwd = (ack_q == 2'b00) && (byte_cnt < len_q);
        end else if (!reply_ack_vld) begin
          case (ack_q)
            2'b00: begin
              finish     = 1'b1;
              fin_status = 2'b00;
            end
            2'b10: begin
              retry_event  = 1'b1;
              event_status = 2'b11;
            end
            default: begin
              finish     = 1'b1;
              fin_status = 2'b01;
            end
          endcase
        end
      end
      S_GAP: begin
        if (gap_cnt == G_LAST) begin
          fire_retry = 1'b1;
          state_nxt  = S_WAIT_TX;
        end
      end
      S_WAIT_TX: begin
        if (req_sent) begin
          rearm     = 1'b1;
          state_nxt = S_WAIT_REPLY;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (retry_event) begin
      if (retry_cnt == MAX_Q) begin
        finish     = 1'b1;
        fin_status = event_status;
      end else begin
        to_gap    = 1'b1;
        state_nxt = S_GAP;
      end
    end
    if (finish) state_nxt = S_IDLE;
  end

  // Counters, latched reply info and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_q         <= '0;
      byte_cnt      <= '0;
      retry_cnt     <= '0;
      timer         <= '0;
      gap_cnt       <= '0;
      ack_q         <= '0;
      i2c_q         <= 1'b0;
      rd_data       <= '0;
      rd_data_vld   <= 1'b0;
      retry_req     <= 1'b0;
      done          <= 1'b0;
      status        <= '0;
      rx_len        <= '0;
      rx_i2c_native <= 1'b0;
    end else begin
      rd_data_vld <= 1'b0;
      retry_req   <= fire_retry;
      done        <= finish;
      if (state == S_WAIT_REPLY && timer != T_MAX) timer <= timer + TW'(1);
      if (start) begin
        len_q     <= req_len;
        retry_cnt <= '0;
        byte_cnt  <= '0;
        timer     <= '0;
      end
      if (rearm) timer <= '0;
      if (latch_reply) begin
        ack_q <= reply_ack;
        i2c_q <= reply_dec_i2c_native;
      end
      if (fwd) begin
        rd_data     <= reply_data;
        rd_data_vld <= 1'b1;
        byte_cnt    <= byte_cnt + 5'd1;
      end
      if (to_gap) begin
        retry_cnt <= retry_cnt + 3'd1;
        byte_cnt  <= '0;
        gap_cnt   <= '0;
      end else if (state == S_GAP) begin
        gap_cnt <= gap_cnt + GW'(1);
      end
      if (finish) begin
        status        <= fin_status;
        rx_len        <= byte_cnt;
        rx_i2c_native <= i2c_q;
      end
    end
  end

endmodule

// File: tb/tb_aux_reply_ctrl.sv
// tb/tb_aux_reply_ctrl.sv - scoreboard bench for aux_reply_ctrl
module tb_aux_reply_ctrl;

  localparam int TO = 40;
  localparam int MR = 2;
  localparam int G  = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_sent = 1'b0;
  logic [4:0] req_len = '0;
  logic [1:0] reply_ack = '0;
  logic       reply_ack_vld = 1'b0;
  logic [7:0] reply_data = '0;
  logic       reply_data_vld = 1'b0;
  logic       reply_dec_i2c_native = 1'b0;
  logic [7:0] rd_data;
  logic       rd_data_vld;
  logic       retry_req;
  logic       busy;
  logic       done;
  logic [1:0] status;
  logic [4:0] rx_len;
  logic       rx_i2c_native;

  aux_reply_ctrl #(.TIMEOUT_CYCLES(TO), .MAX_RETRY(MR), .RETRY_GAP(G)) dut (
    .clk(clk), .rst(rst), .req_sent(req_sent), .req_len(req_len),
    .reply_ack(reply_ack), .reply_ack_vld(reply_ack_vld), .reply_data(reply_data),
    .reply_data_vld(reply_data_vld), .reply_dec_i2c_native(reply_dec_i2c_native),
    .rd_data(rd_data), .rd_data_vld(rd_data_vld), .retry_req(retry_req), .busy(busy),
    .done(done), .status(status), .rx_len(rx_len), .rx_i2c_native(rx_i2c_native)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct {logic [7:0] data; int cyc;} rd_exp_t;
  typedef struct {logic [1:0] st; logic [4:0] len; logic i2c; bit chk_i2c; int cyc;} done_exp_t;
  typedef struct {int kind; int k; int n; bit i2c;} att_t;  // kind 0..3 reply code, 4 no reply

  rd_exp_t   rd_q[$];
  done_exp_t done_q[$];
  int        retry_q[$];
  att_t      plan_q[$];
  rd_exp_t   mon_rd;
  done_exp_t mon_done;
  int        mon_rt;
  bit        use_pat = 1'b1;
  int        n_cmp = 0;
  int        n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every DUT output event is matched against the head of its expectation queue.
  always @(negedge clk) begin
    if (rst) begin
      if (rd_data_vld) begin
        chk("rd_expected", 32'(rd_q.size() > 0), 1);
        if (rd_q.size() > 0) begin
          mon_rd = rd_q.pop_front();
          chk("rd_data", rd_data, mon_rd.data);
          chk("rd_cycle", cyc, mon_rd.cyc);
        end
      end
      if (retry_req) begin
        chk("retry_expected", 32'(retry_q.size() > 0), 1);
        if (retry_q.size() > 0) begin
          mon_rt = retry_q.pop_front();
          chk("retry_cycle", cyc, mon_rt);
        end
      end
      if (done) begin
        chk("done_expected", 32'(done_q.size() > 0), 1);
        chk("done_busy", busy, 0);
        if (done_q.size() > 0) begin
          mon_done = done_q.pop_front();
          chk("done_cycle", cyc, mon_done.cyc);
          chk("status", status, mon_done.st);
          chk("rx_len", rx_len, mon_done.len);
          if (mon_done.chk_i2c) chk("rx_i2c", rx_i2c_native, mon_done.i2c);
        end
      end
    end
  end

  function automatic att_t rand_att(input bit force_retry);
    att_t t;
    int r = $urandom_range(0, 9);
    if (force_retry) r = 6 + (r % 4);
    t.kind = (r <= 3) ? 0 : (r == 4) ? 1 : (r == 5) ? 3 : (r <= 7) ? 2 : 4;
    t.k    = ($urandom_range(0, 7) == 0) ? TO : $urandom_range(1, TO);
    t.n    = $urandom_range(0, 20);
    t.i2c  = 1'($urandom_range(0, 1));
    return t;
  endfunction

  // One full exchange; expected outcomes follow from the attempt list alone.
  task automatic do_txn(input int len, input bit force_retry);
    att_t at;
    int a = 0;
    int t0;
    int d;
    int nfw;
    bit fin = 1'b0;
    logic [7:0] v;
    while (!fin) begin
      if (plan_q.size() > 0) at = plan_q.pop_front();
      else at = rand_att(force_retry);
      req_sent = 1'b1;
      req_len  = (a == 0) ? 5'(len) : 5'($urandom_range(0, 31));
      t0 = cyc + 1;
      @(negedge clk);
      req_sent = 1'b0;
      nfw = 0;
      if (at.kind == 4) begin
        d = t0 + TO;
      end else begin
        while (cyc < t0 + at.k - 1) @(negedge clk);
        reply_ack_vld        = 1'b1;
        reply_ack            = 2'(at.kind);
        reply_dec_i2c_native = at.i2c;
        for (int i = 0; i < at.n; i++) begin
          @(negedge clk);
          reply_ack_vld  = 1'b0;
          v = use_pat ? 8'((i + 1) * 17) : 8'($urandom);
          reply_data_vld = 1'b1;
          reply_data     = v;
          if (at.kind == 0 && i < len) begin
            rd_q.push_back('{v, cyc + 1});
            nfw++;
          end
        end
        @(negedge clk);
        reply_ack_vld        = 1'b0;
        reply_data_vld       = 1'b0;
        reply_ack            = 2'($urandom);
        reply_data           = 8'($urandom);
        reply_dec_i2c_native = 1'($urandom);
        d = cyc + 1;
      end
      if (at.kind == 0) begin
        done_q.push_back('{2'b00, 5'(nfw), at.i2c, 1'b1, d});
        fin = 1'b1;
      end else if (at.kind == 1 || at.kind == 3) begin
        done_q.push_back('{2'b01, 5'd0, at.i2c, 1'b1, d});
        fin = 1'b1;
      end else if (a == MR) begin
        done_q.push_back('{(at.kind == 2) ? 2'b11 : 2'b10, 5'd0, at.i2c, at.kind != 4, d});
        fin = 1'b1;
      end else begin
        retry_q.push_back(d + G);
        while (cyc < d + 1) @(negedge clk);
        if ($urandom_range(0, 1) == 1) begin
          req_sent = 1'b1;
          @(negedge clk);
          req_sent = 1'b0;
        end
        while (cyc < d + G) @(negedge clk);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        a++;
      end
    end
    while (cyc < d) @(negedge clk);
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_data"}, rd_data, 0);
    chk({tag, "_rd_data_vld"}, rd_data_vld, 0);
    chk({tag, "_retry_req"}, retry_req, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_status"}, status, 0);
    chk({tag, "_rx_len"}, rx_len, 0);
    chk({tag, "_rx_i2c"}, rx_i2c_native, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: bench did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    // ACK read, over-length, NACK
    plan_q.push_back('{0, 3, 4, 1'b0});
    do_txn(4, 1'b0);
    plan_q.push_back('{0, 2, 4, 1'b1});
    do_txn(2, 1'b0);
    plan_q.push_back('{1, 2, 1, 1'b0});
    do_txn(4, 1'b0);
    // DEFER then ACK
    plan_q.push_back('{2, 3, 0, 1'b1});
    plan_q.push_back('{0, 2, 1, 1'b0});
    do_txn(1, 1'b0);
    // timeout exhaustion
    repeat (3) plan_q.push_back('{4, 1, 0, 1'b0});
    do_txn(3, 1'b0);

    // reset in RECV after two forwarded bytes
    req_sent = 1'b1;
    req_len  = 5'd4;
    @(negedge clk);
    req_sent = 1'b0;
    reply_ack_vld = 1'b1;
    reply_ack     = 2'b00;
    reply_dec_i2c_native = 1'b1;
    @(negedge clk);
    reply_ack_vld  = 1'b0;
    reply_data_vld = 1'b1;
    reply_data     = 8'h11;
    rd_q.push_back('{8'h11, cyc + 1});
    @(negedge clk);
    reply_data = 8'h22;
    rd_q.push_back('{8'h22, cyc + 1});
    @(negedge clk);
    reply_data = 8'h33;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_all_zero("midreset");
    reply_data_vld = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);

    // reply on the expiry cycle, DEFER exhaustion, zero length, max length
    plan_q.push_back('{0, TO, 2, 1'b1});
    do_txn(5, 1'b0);
    repeat (3) plan_q.push_back('{2, 1, 2, 1'b1});
    do_txn(2, 1'b0);
    plan_q.push_back('{0, 1, 3, 1'b0});
    do_txn(0, 1'b0);
    plan_q.push_back('{0, 5, 18, 1'b1});
    do_txn(16, 1'b0);

    use_pat = 1'b0;
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        reply_ack_vld  = 1'b1;
        reply_data_vld = 1'b1;
        reply_ack      = 2'b00;
        reply_data     = 8'($urandom);
        @(negedge clk);
        reply_ack_vld  = 1'b0;
        reply_data_vld = 1'b0;
      end
      do_txn($urandom_range(0, 16), $urandom_range(0, 3) == 0);
    end

    repeat (G + 8) @(negedge clk);
    chk("rd_left", rd_q.size(), 0);
    chk("retry_left", retry_q.size(), 0);
    chk("done_left", done_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
